// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86-64 constants (icodes, status codes, register IDs) and the
// performance-counter slot layout used by the pipeline control unit.
package pipe_ctrl_pkg;

  localparam int NIBBLE = 4;
  localparam int D_WORD = 64;

  // Instruction codes
  localparam logic [NIBBLE-1:0] IHALT   = 4'h0;
  localparam logic [NIBBLE-1:0] INOP    = 4'h1;
  localparam logic [NIBBLE-1:0] IRRMOVQ = 4'h2;
  localparam logic [NIBBLE-1:0] IIRMOVQ = 4'h3;
  localparam logic [NIBBLE-1:0] IRMMOVQ = 4'h4;
  localparam logic [NIBBLE-1:0] IMRMOVQ = 4'h5;
  localparam logic [NIBBLE-1:0] IOPQ    = 4'h6;
  localparam logic [NIBBLE-1:0] IJXX    = 4'h7;
  localparam logic [NIBBLE-1:0] ICALL   = 4'h8;
  localparam logic [NIBBLE-1:0] IRET    = 4'h9;
  localparam logic [NIBBLE-1:0] IPUSHQ  = 4'hA;
  localparam logic [NIBBLE-1:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [NIBBLE-1:0] SAOK = 4'h1;
  localparam logic [NIBBLE-1:0] SHLT = 4'h2;
  localparam logic [NIBBLE-1:0] SADR = 4'h3;
  localparam logic [NIBBLE-1:0] SINS = 4'h4;

  localparam logic [NIBBLE-1:0] RNONE = 4'hF;

  // Performance counter slots
  localparam int NUM_CNT     = 5;
  localparam int CNT_CYC     = 0;
  localparam int CNT_RET     = 1;
  localparam int CNT_LU      = 2;
  localparam int CNT_MP      = 3;
  localparam int CNT_RSTALL  = 4;

  // A status that stops the machine once it reaches writeback.
  function automatic logic is_exc(input logic [NIBBLE-1:0] stat);
    return (stat == SADR) || (stat == SINS) || (stat == SHLT);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard inputs and control/status outputs between the pipeline
// datapath (master) and the pipeline control unit (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic              start_i;
  logic              clear_i;
  logic [NIBBLE-1:0] D_icode_i;
  logic [NIBBLE-1:0] d_srcA_i;
  logic [NIBBLE-1:0] d_srcB_i;
  logic [NIBBLE-1:0] E_icode_i;
  logic [NIBBLE-1:0] E_dstM_i;
  logic              e_Cnd_i;
  logic [NIBBLE-1:0] M_icode_i;
  logic [NIBBLE-1:0] m_stat_i;
  logic [NIBBLE-1:0] W_icode_i;
  logic [NIBBLE-1:0] W_stat_i;

  logic              F_stall_o;
  logic              D_stall_o;
  logic              D_bubble_o;
  logic              E_bubble_o;
  logic              M_bubble_o;
  logic              W_stall_o;
  logic              set_cc_o;
  logic              running_o;
  logic              halted_o;
  logic [NIBBLE-1:0] stat_o;
  logic [CNT_W-1:0]  cyc_cnt_o;
  logic [CNT_W-1:0]  ret_cnt_o;
  logic [CNT_W-1:0]  lu_cnt_o;
  logic [CNT_W-1:0]  mp_cnt_o;
  logic [CNT_W-1:0]  ret_stall_cnt_o;

  modport master (
    output start_i, clear_i, D_icode_i, d_srcA_i, d_srcB_i, E_icode_i,
           E_dstM_i, e_Cnd_i, M_icode_i, m_stat_i, W_icode_i, W_stat_i,
    input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
           W_stall_o, set_cc_o, running_o, halted_o, stat_o, cyc_cnt_o,
           ret_cnt_o, lu_cnt_o, mp_cnt_o, ret_stall_cnt_o
  );

  modport slave (
    input  start_i, clear_i, D_icode_i, d_srcA_i, d_srcB_i, E_icode_i,
           E_dstM_i, e_Cnd_i, M_icode_i, m_stat_i, W_icode_i, W_stat_i,
    output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
           W_stall_o, set_cc_o, running_o, halted_o, stat_o, cyc_cnt_o,
           ret_cnt_o, lu_cnt_o, mp_cnt_o, ret_stall_cnt_o
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Bank of wrapping event counters, each with its own increment enable and a
// shared synchronous clear that takes priority over counting.
module pipe_perf_cnt #(
  parameter int CNT_W = 32,
  parameter int N     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [N-1:0]              inc,
  output logic [N-1:0][CNT_W-1:0]   cnt
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (clr) begin
          cnt_reg <= '0;
        end else if (inc[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt[gi] = cnt_reg;
    end
  endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: combinational stall/bubble generation from hazard
// terms, an IDLE/RUN/STOP run-state machine, and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [NIBBLE-1:0] stat_reg, stat_next;
  logic              cnt_clr;

  logic load_use, ret_pend, mispred, m_exc, w_exc, ret_retire;

  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;

  always_comb begin
    load_use   = ((bus.E_icode_i == IMRMOVQ) || (bus.E_icode_i == IPOPQ)) &&
                 ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
    ret_pend   = (bus.D_icode_i == IRET) || (bus.E_icode_i == IRET) ||
                 (bus.M_icode_i == IRET);
    mispred    = (bus.E_icode_i == IJXX) && !bus.e_Cnd_i;
    m_exc      = is_exc(bus.m_stat_i);
    w_exc      = is_exc(bus.W_stat_i);
    ret_retire = (bus.W_icode_i == IRET) && (bus.W_stat_i == SAOK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      stat_reg  <= SAOK;
    end else begin
      state_reg <= state_next;
      stat_reg  <= stat_next;
    end
  end

  // Outside RUN the pipe is frozen at fetch and flushed with bubbles; STOP
  // additionally holds W so the faulting instruction stays visible.
  always_comb begin
    state_next     = state_reg;
    stat_next      = stat_reg;
    cnt_clr        = 1'b0;
    bus.F_stall_o  = 1'b1;
    bus.D_stall_o  = 1'b0;
    bus.D_bubble_o = 1'b1;
    bus.E_bubble_o = 1'b1;
    bus.M_bubble_o = 1'b1;
    bus.W_stall_o  = 1'b0;
    bus.set_cc_o   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.start_i) begin
          state_next = S_RUN;
          cnt_clr    = 1'b1;
        end
      end

      S_RUN: begin
        bus.F_stall_o  = load_use | ret_pend;
        bus.D_stall_o  = load_use;
        // A load/use stall wins over the ret bubble so D keeps its instruction.
        bus.D_bubble_o = mispred | (!load_use & ret_pend);
        bus.E_bubble_o = mispred | load_use;
        bus.M_bubble_o = m_exc | w_exc;
        bus.W_stall_o  = w_exc;
        bus.set_cc_o   = (bus.E_icode_i == IOPQ) & !m_exc & !w_exc;
        if (w_exc) begin
          state_next = S_STOP;
          stat_next  = bus.W_stat_i;
        end
      end

      S_STOP: begin
        bus.W_stall_o = 1'b1;
        if (bus.clear_i) begin
          state_next = S_IDLE;
          stat_next  = SAOK;
        end
      end

      default: begin
        state_next = S_IDLE;
        stat_next  = SAOK;
      end
    endcase
  end

  always_comb begin
    cnt_inc             = '0;
    cnt_inc[CNT_CYC]    = 1'b1;
    cnt_inc[CNT_RET]    = ret_retire;
    cnt_inc[CNT_LU]     = load_use;
    cnt_inc[CNT_MP]     = mispred;
    cnt_inc[CNT_RSTALL] = ret_pend & !load_use;
    if (state_reg != S_RUN) begin
      cnt_inc = '0;
    end
  end

  pipe_perf_cnt #(
    .CNT_W (CNT_W),
    .N     (NUM_CNT)
  ) u_perf_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt)
  );

  assign bus.running_o       = (state_reg == S_RUN);
  assign bus.halted_o        = (state_reg == S_STOP);
  assign bus.stat_o          = stat_reg;
  assign bus.cyc_cnt_o       = cnt[CNT_CYC];
  assign bus.ret_cnt_o       = cnt[CNT_RET];
  assign bus.lu_cnt_o        = cnt[CNT_LU];
  assign bus.mp_cnt_o        = cnt[CNT_MP];
  assign bus.ret_stall_cnt_o = cnt[CNT_RSTALL];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl, checked against a behavioural
// model of the hazard rules, run/stop sequencing and event counters.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus();

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit       start, clear;
    bit [3:0] d_ic, src_a, src_b, e_ic, e_dstm;
    bit       e_cnd;
    bit [3:0] m_ic, m_stat, w_ic, w_stat;
  } vec_t;

  typedef enum {M_IDLE, M_RUN, M_STOP} mst_t;

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  localparam bit [6:0] CTRL_IDLE = 7'b1011100;
  localparam bit [6:0] CTRL_STOP = 7'b1011110;

  int n_vec = 0;
  int n_bad = 0;

  mst_t          m_st;
  bit [3:0]      m_stat_q;
  bit [CW-1:0]   m_cnt [5];

  logic [6:0]    obs_ctrl;
  logic          obs_run, obs_halt;
  logic [3:0]    obs_stat;
  logic [CW-1:0] obs_cnt [5];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit lu_of(vec_t v);
    return ((v.e_ic == IMRMOVQ) || (v.e_ic == IPOPQ)) &&
           ((v.e_dstm == v.src_a) || (v.e_dstm == v.src_b));
  endfunction
  function automatic bit rp_of(vec_t v);
    return (v.d_ic == IRET) || (v.e_ic == IRET) || (v.m_ic == IRET);
  endfunction
  function automatic bit mp_of(vec_t v);
    return (v.e_ic == IJXX) && !v.e_cnd;
  endfunction
  function automatic bit exc_of(bit [3:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

  function automatic bit [6:0] ref_ctrl(vec_t v, mst_t st);
    bit lu, rp, mp, me, we;
    lu = lu_of(v);
    rp = rp_of(v);
    mp = mp_of(v);
    me = exc_of(v.m_stat);
    we = exc_of(v.w_stat);
    if (st == M_IDLE) return CTRL_IDLE;
    if (st == M_STOP) return CTRL_STOP;
    return {lu | rp, lu, mp | (rp & !lu), mp | lu, me | we, we,
            (v.e_ic == IOPQ) & !me & !we};
  endfunction

  function automatic vec_t nop_vec();
    vec_t v;
    v = '{default: 0};
    v.d_ic = INOP;  v.e_ic = INOP;  v.m_ic = INOP;  v.w_ic = INOP;
    v.src_a = RNONE; v.src_b = RNONE; v.e_dstm = RNONE;
    v.m_stat = SAOK; v.w_stat = SAOK;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.start  = ($urandom_range(0, 7) == 0);
    v.clear  = ($urandom_range(0, 7) == 0);
    v.d_ic   = 4'($urandom_range(0, 11));
    v.e_ic   = 4'($urandom_range(0, 11));
    v.m_ic   = 4'($urandom_range(0, 11));
    v.w_ic   = 4'($urandom_range(0, 11));
    v.src_a  = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 3));
    v.src_b  = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 3));
    v.e_dstm = 4'($urandom_range(0, 3));
    v.e_cnd  = 1'($urandom_range(0, 1));
    v.m_stat = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 4)) : SAOK;
    v.w_stat = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(2, 4)) : SAOK;
    return v;
  endfunction

  task automatic drive(vec_t v);
    bus.start_i   = v.start;   bus.clear_i  = v.clear;
    bus.D_icode_i = v.d_ic;    bus.d_srcA_i = v.src_a;  bus.d_srcB_i = v.src_b;
    bus.E_icode_i = v.e_ic;    bus.E_dstM_i = v.e_dstm; bus.e_Cnd_i  = v.e_cnd;
    bus.M_icode_i = v.m_ic;    bus.m_stat_i = v.m_stat;
    bus.W_icode_i = v.w_ic;    bus.W_stat_i = v.w_stat;
  endtask

  task automatic model_reset();
    m_st = M_IDLE;
    m_stat_q = SAOK;
    for (int i = 0; i < 5; i++) m_cnt[i] = '0;
  endtask

  task automatic model_step(vec_t v);
    case (m_st)
      M_IDLE: if (v.start) begin
        m_st = M_RUN;
        for (int i = 0; i < 5; i++) m_cnt[i] = '0;
      end
      M_RUN: begin
        m_cnt[0]++;
        if (v.w_ic == IRET && v.w_stat == SAOK) m_cnt[1]++;
        if (lu_of(v)) m_cnt[2]++;
        if (mp_of(v)) m_cnt[3]++;
        if (rp_of(v) && !lu_of(v)) m_cnt[4]++;
        if (exc_of(v.w_stat)) begin
          m_st = M_STOP;
          m_stat_q = v.w_stat;
        end
      end
      default: if (v.clear) begin
        m_st = M_IDLE;
        m_stat_q = SAOK;
      end
    endcase
  endtask

  task automatic sample();
    obs_ctrl = {bus.F_stall_o, bus.D_stall_o, bus.D_bubble_o, bus.E_bubble_o,
                bus.M_bubble_o, bus.W_stall_o, bus.set_cc_o};
    obs_run  = bus.running_o;
    obs_halt = bus.halted_o;
    obs_stat = bus.stat_o;
    obs_cnt[0] = bus.cyc_cnt_o;
    obs_cnt[1] = bus.ret_cnt_o;
    obs_cnt[2] = bus.lu_cnt_o;
    obs_cnt[3] = bus.mp_cnt_o;
    obs_cnt[4] = bus.ret_stall_cnt_o;
  endtask

  // Entered just after a rising edge; leaves 1 time unit after the next one.
  task automatic apply(vec_t v);
    string names [5] = '{"cyc_cnt", "ret_cnt", "lu_cnt", "mp_cnt", "ret_stall_cnt"};
    drive(v);
    @(negedge clk);
    sample();
    check_val("ctrl", 64'(obs_ctrl), 64'(ref_ctrl(v, m_st)));
    check_val("running", 64'(obs_run), 64'(m_st == M_RUN));
    check_val("halted", 64'(obs_halt), 64'(m_st == M_STOP));
    check_val("stat", 64'(obs_stat), 64'(m_stat_q));
    for (int i = 0; i < 5; i++) check_val(names[i], 64'(obs_cnt[i]), 64'(m_cnt[i]));
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [CW-1:0] base_a, base_b;

    model_reset();
    drive(nop_vec());
    #12;
    sample();
    check_val("rst_ctrl", 64'(obs_ctrl), 64'(CTRL_IDLE));
    check_val("rst_stat", 64'(obs_stat), 64'd1);
    check_val("rst_running", 64'(obs_run), 64'd0);
    check_val("rst_cyc", 64'(obs_cnt[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // start, then 57 run cycles, then async reset in the middle of a cycle
    v = nop_vec(); v.start = 1'b1; apply(v);
    repeat (57) apply(nop_vec());
    drive(nop_vec());
    #1;
    check_val("cyc_57", 64'(bus.cyc_cnt_o), 64'd57);
    #2;
    rst = 1'b1;
    #1;
    sample();
    model_reset();
    check_val("midrst_ctrl", 64'(obs_ctrl), 64'(CTRL_IDLE));
    check_val("midrst_cyc", 64'(obs_cnt[0]), 64'd0);
    check_val("midrst_stat", 64'(obs_stat), 64'd1);
    check_val("midrst_running", 64'(obs_run), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    v = nop_vec(); v.start = 1'b1; apply(v);

    // load/use
    v = nop_vec(); v.e_ic = IMRMOVQ; v.e_dstm = 4'd3; v.src_a = 4'd3; apply(v);
    base_a = obs_cnt[2];
    check_val("lu_fstall", 64'(obs_ctrl[6]), 64'd1);
    check_val("lu_dstall", 64'(obs_ctrl[5]), 64'd1);
    check_val("lu_dbubble", 64'(obs_ctrl[4]), 64'd0);
    check_val("lu_ebubble", 64'(obs_ctrl[3]), 64'd1);
    apply(nop_vec());
    check_val("lu_cnt_inc", 64'(obs_cnt[2]), 64'(base_a + 1));

    // ret travels D -> E -> M -> W
    v = nop_vec(); v.d_ic = IRET; apply(v);
    base_a = obs_cnt[4]; base_b = obs_cnt[1];
    check_val("ret_db_d", 64'(obs_ctrl[4]), 64'd1);
    v = nop_vec(); v.e_ic = IRET; apply(v);
    check_val("ret_db_e", 64'(obs_ctrl[4]), 64'd1);
    v = nop_vec(); v.m_ic = IRET; apply(v);
    check_val("ret_db_m", 64'(obs_ctrl[4]), 64'd1);
    v = nop_vec(); v.w_ic = IRET; apply(v);
    check_val("ret_db_w", 64'(obs_ctrl[4]), 64'd0);
    apply(nop_vec());
    check_val("ret_stall_3", 64'(obs_cnt[4]), 64'(base_a + 3));
    check_val("ret_retired", 64'(obs_cnt[1]), 64'(base_b + 1));

    // mispredict, then a correctly predicted jump
    v = nop_vec(); v.e_ic = IJXX; v.e_cnd = 1'b0; apply(v);
    base_a = obs_cnt[3];
    check_val("mp_dbubble", 64'(obs_ctrl[4]), 64'd1);
    check_val("mp_ebubble", 64'(obs_ctrl[3]), 64'd1);
    check_val("mp_fstall", 64'(obs_ctrl[6]), 64'd0);
    v.e_cnd = 1'b1; apply(v);
    check_val("jtaken_bubbles", 64'(obs_ctrl[4:3]), 64'd0);
    check_val("mp_cnt_inc", 64'(obs_cnt[3]), 64'(base_a + 1));

    // load/use together with ret in D
    v = nop_vec(); v.e_ic = IMRMOVQ; v.e_dstm = 4'd2; v.src_b = 4'd2; v.d_ic = IRET;
    apply(v);
    check_val("luret_dstall", 64'(obs_ctrl[5]), 64'd1);
    check_val("luret_dbubble", 64'(obs_ctrl[4]), 64'd0);
    check_val("luret_ebubble", 64'(obs_ctrl[3]), 64'd1);

    // exception in M, then W, then stop / clear / restart
    v = nop_vec(); v.e_ic = IOPQ; v.m_stat = SADR; apply(v);
    check_val("exc_mbubble", 64'(obs_ctrl[2]), 64'd1);
    check_val("exc_setcc", 64'(obs_ctrl[0]), 64'd0);
    v = nop_vec(); v.w_stat = SADR; apply(v);
    check_val("exc_wstall", 64'(obs_ctrl[1]), 64'd1);
    check_val("exc_not_halted", 64'(obs_halt), 64'd0);
    apply(nop_vec());
    check_val("exc_halted", 64'(obs_halt), 64'd1);
    check_val("exc_stat", 64'(obs_stat), 64'd3);
    v = nop_vec(); v.clear = 1'b1; apply(v);
    apply(nop_vec());
    check_val("clr_stat", 64'(obs_stat), 64'd1);
    check_val("clr_halted", 64'(obs_halt), 64'd0);
    v = nop_vec(); v.start = 1'b1; apply(v);
    apply(nop_vec());
    check_val("restart_cyc", 64'(obs_cnt[0]), 64'd0);
    check_val("restart_running", 64'(obs_run), 64'd1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) apply(rand_vec());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
